// File: rtl/rc_adaptive_unit.sv
// Mesh NoC route computation with minimal-adaptive X/Y choice and wormhole lock; 1-cycle accept-to-valid latency.
// Two-entry output/skid buffer; ready_out drops only when the skid entry fills. RC_PKT_CNT_EN adds per-direction head counters.
module rc_adaptive_unit #(
    parameter int DATASIZE = 40,
    parameter int COORD_W  = 2,
    parameter int DST_LSB  = 32,
    parameter int MESH_X   = 3,
    parameter int MESH_Y   = 3,
    parameter int MY_X     = 2,
    parameter int MY_Y     = 0,
    parameter int WIDTH    = 3
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    output logic [3:0]          direction_out,
    input  logic                rc_ready,
    input  logic [WIDTH:0]      N_pressure_in,
    input  logic [WIDTH:0]      E_pressure_in,
    input  logic [WIDTH:0]      S_pressure_in,
    input  logic [WIDTH:0]      W_pressure_in
`ifdef RC_PKT_CNT_EN
    ,
    output logic [79:0]         pkt_cnt
`endif
);

    localparam logic [3:0] DIR_W = 4'b1000, DIR_N = 4'b0100, DIR_E = 4'b0010, DIR_S = 4'b0001;
    localparam logic [3:0] DIR_LOCAL = 4'b0000, DIR_NONE = 4'b1111;
    localparam logic [1:0] TY_BODY = 2'b00, TY_HEAD = 2'b01, TY_TAIL = 2'b10, TY_SINGLE = 2'b11;
    localparam logic [COORD_W:0]   LIM_X = (COORD_W+1)'(MESH_X);
    localparam logic [COORD_W:0]   LIM_Y = (COORD_W+1)'(MESH_Y);
    localparam logic [COORD_W-1:0] POS_X = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] POS_Y = COORD_W'(MY_Y);

    typedef enum logic {UNLOCKED, LOCKED} lock_t;

    lock_t              lock_q, lock_d;
    logic [3:0]         lock_dir_q, lock_dir_d;
    logic [3:0]         route, in_dir, x_dir, y_dir;
    logic [WIDTH:0]     x_p, y_p;
    logic [COORD_W-1:0] dst_col, dst_row;
    logic [1:0]         in_type;
    logic               accept, drain, out_free;

    logic [DATASIZE-1:0] skid_dat;
    logic [3:0]          skid_dir, out_dir;
    logic                skid_vld;

    assign dst_col  = data_in[DST_LSB +: COORD_W];
    assign dst_row  = data_in[DST_LSB+COORD_W +: COORD_W];
    assign in_type  = data_in[1:0];
    assign accept   = valid_in && ready_out;
    assign drain    = valid_out && rc_ready;
    assign out_free = !valid_out || drain;

    always_comb begin
        x_dir = (dst_col > POS_X) ? DIR_E : DIR_W;
        x_p   = (dst_col > POS_X) ? E_pressure_in : W_pressure_in;
        y_dir = (dst_row > POS_Y) ? DIR_S : DIR_N;
        y_p   = (dst_row > POS_Y) ? S_pressure_in : N_pressure_in;
        route = DIR_NONE;
        if ({1'b0, dst_col} >= LIM_X || {1'b0, dst_row} >= LIM_Y)
            route = DIR_NONE;
        else if (dst_col == POS_X && dst_row == POS_Y)
            route = DIR_LOCAL;
        else if (dst_row == POS_Y)
            route = x_dir;
        else if (dst_col == POS_X)
            route = y_dir;
        else
            route = (x_p <= y_p) ? x_dir : y_dir;
    end

    // Lock FSM only advances on an actual accept; in_dir is what gets stored with the flit.
    always_comb begin
        lock_d     = lock_q;
        lock_dir_d = lock_dir_q;
        in_dir     = DIR_NONE;
        case (in_type)
            TY_SINGLE: in_dir = route;
            TY_HEAD: begin
                in_dir = route;
                if (accept) begin
                    lock_d     = LOCKED;
                    lock_dir_d = route;
                end
            end
            TY_BODY: in_dir = (lock_q == LOCKED) ? lock_dir_q : DIR_NONE;
            TY_TAIL: begin
                in_dir = (lock_q == LOCKED) ? lock_dir_q : DIR_NONE;
                if (accept && lock_q == LOCKED)
                    lock_d = UNLOCKED;
            end
            default: in_dir = DIR_NONE;
        endcase
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= UNLOCKED;
            lock_dir_q <= DIR_NONE;
        end else begin
            lock_q     <= lock_d;
            lock_dir_q <= lock_dir_d;
        end
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_dir   <= DIR_NONE;
            valid_out <= 1'b0;
            skid_dat  <= '0;
            skid_dir  <= DIR_NONE;
            skid_vld  <= 1'b0;
            ready_out <= 1'b1;
        end else if (out_free) begin
            if (skid_vld) begin
                data_out  <= skid_dat;
                out_dir   <= skid_dir;
                valid_out <= 1'b1;
                skid_vld  <= 1'b0;
                ready_out <= 1'b1;
            end else if (accept) begin
                data_out  <= data_in;
                out_dir   <= in_dir;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
        end else if (accept) begin
            skid_dat  <= data_in;
            skid_dir  <= in_dir;
            skid_vld  <= 1'b1;
            ready_out <= 1'b0;
        end
    end

    assign direction_out = valid_out ? out_dir : DIR_NONE;

`ifdef RC_PKT_CNT_EN
    logic [15:0] cnt [5];
    logic [2:0]  cnt_idx;
    logic        cnt_hit;

    always_comb begin
        cnt_hit = drain && data_out[0];
        cnt_idx = 3'd0;
        case (out_dir)
            DIR_W:     cnt_idx = 3'd4;
            DIR_N:     cnt_idx = 3'd3;
            DIR_E:     cnt_idx = 3'd2;
            DIR_S:     cnt_idx = 3'd1;
            DIR_LOCAL: cnt_idx = 3'd0;
            default:   cnt_hit = 1'b0;
        endcase
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else if (cnt_hit && cnt[cnt_idx] != 16'hFFFF) begin
            cnt[cnt_idx] <= cnt[cnt_idx] + 16'd1;
        end
    end

    assign pkt_cnt = {cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_rc_adaptive_unit.sv
// Directed bench for rc_adaptive_unit at node (col 2, row 0) of a 3x3 mesh.
module tb_rc_adaptive_unit;

    logic        rc_clk = 1'b0;
    logic        rst_n;
    logic [39:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [39:0] data_out;
    logic        valid_out;
    logic [3:0]  direction_out;
    logic        rc_ready;
    logic [3:0]  N_pressure_in, E_pressure_in, S_pressure_in, W_pressure_in;
`ifdef RC_PKT_CNT_EN
    logic [79:0] pkt_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] fa, fb, fc;

    always #5 rc_clk = ~rc_clk;

    rc_adaptive_unit dut (
        .rc_clk        (rc_clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .direction_out (direction_out),
        .rc_ready      (rc_ready),
        .N_pressure_in (N_pressure_in),
        .E_pressure_in (E_pressure_in),
        .S_pressure_in (S_pressure_in),
        .W_pressure_in (W_pressure_in)
`ifdef RC_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [3:0] dst, input logic [1:0] ty, input logic [21:0] pl);
        return {4'h5, dst, 8'hA5, pl, ty};
    endfunction

    task automatic set_p(input logic [3:0] n, input logic [3:0] e, input logic [3:0] s, input logic [3:0] w);
        N_pressure_in = n; E_pressure_in = e; S_pressure_in = s; W_pressure_in = w;
    endtask

    // Drives one flit for one cycle with rc_ready high, then checks it at the output.
    task automatic xfer(input string tag, input logic [39:0] f, input logic [3:0] d);
        rc_ready = 1'b1;
        valid_in = 1'b1;
        data_in  = f;
        @(negedge rc_clk);
        chk({tag, ".vld"}, 80'(valid_out), 80'(1'b1));
        chk({tag, ".dir"}, 80'(direction_out), 80'(d));
        chk({tag, ".dat"}, 80'(data_out), 80'(f));
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; rc_ready = 1'b0;
        set_p(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge rc_clk);
        chk("rst.vld", 80'(valid_out), 80'(1'b0));
        chk("rst.dir", 80'(direction_out), 80'(4'b1111));
        chk("rst.rdy", 80'(ready_out), 80'(1'b1));
        chk("rst.dat", 80'(data_out), 80'(0));
        rst_n = 1'b1;
        @(negedge rc_clk);

        xfer("local", mk(4'b0010, 2'b11, 22'h00111), 4'b0000);

        set_p(4'd0, 4'd0, 4'd3, 4'd3);
        xfer("tie_x", mk(4'b0100, 2'b11, 22'h00222), 4'b1000);
        set_p(4'd0, 4'd0, 4'd2, 4'd5);
        xfer("y_win", mk(4'b0100, 2'b11, 22'h00333), 4'b0001);
        set_p(4'd0, 4'd0, 4'd15, 4'd15);
        xfer("tie_hi", mk(4'b0100, 2'b11, 22'h00334), 4'b1000);

        set_p(4'd1, 4'd1, 4'd1, 4'd9);
        xfer("wh.head", mk(4'b0110, 2'b01, 22'h00444), 4'b0001);
        set_p(4'd1, 4'd1, 4'd9, 4'd0);
        xfer("wh.body", mk(4'b0000, 2'b00, 22'h00555), 4'b0001);
        set_p(4'd2, 4'd2, 4'd7, 4'd1);
        xfer("wh.tail", mk(4'b1111, 2'b10, 22'h00666), 4'b0001);
        xfer("wh.orphan", mk(4'b0110, 2'b00, 22'h00777), 4'b1111);

        // Head that needs the adaptive choice, then body under reversed pressure keeps it.
        set_p(4'd0, 4'd0, 4'd1, 4'd6);
        xfer("wh2.head", mk(4'b0100, 2'b01, 22'h00888), 4'b0001);
        set_p(4'd0, 4'd0, 4'd6, 4'd1);
        xfer("wh2.body", mk(4'b0100, 2'b00, 22'h00999), 4'b0001);
        xfer("wh2.rehead", mk(4'b0000, 2'b01, 22'h00AAA), 4'b1000);
        xfer("wh2.tail", mk(4'b0100, 2'b10, 22'h00BBB), 4'b1000);

        xfer("oob_col", mk(4'b0011, 2'b11, 22'h00CCC), 4'b1111);
        xfer("oob_row", mk(4'b1110, 2'b11, 22'h00CCD), 4'b1111);
        valid_in = 1'b0;
        @(negedge rc_clk);
        chk("idle.vld", 80'(valid_out), 80'(1'b0));
        chk("idle.dir", 80'(direction_out), 80'(4'b1111));
        chk("idle.hold", 80'(data_out), 80'(mk(4'b1110, 2'b11, 22'h00CCD)));

        fa = mk(4'b0000, 2'b11, 22'h0A0A0);
        fb = mk(4'b0010, 2'b11, 22'h0B0B0);
        fc = mk(4'b1010, 2'b11, 22'h0C0C0);
        rc_ready = 1'b0;
        valid_in = 1'b1; data_in = fa;
        @(negedge rc_clk);
        chk("bp.rdy1", 80'(ready_out), 80'(1'b1));
        data_in = fb;
        @(negedge rc_clk);
        data_in = fc;
        chk("bp.rdy0", 80'(ready_out), 80'(1'b0));
        chk("bp.a_dat", 80'(data_out), 80'(fa));
        repeat (2) @(negedge rc_clk);
        chk("bp.stall_rdy", 80'(ready_out), 80'(1'b0));
        chk("bp.stall_dat", 80'(data_out), 80'(fa));
        chk("bp.a_dir", 80'(direction_out), 80'(4'b1000));
        rc_ready = 1'b1;
        @(negedge rc_clk);
        chk("bp.b_dat", 80'(data_out), 80'(fb));
        chk("bp.b_dir", 80'(direction_out), 80'(4'b0000));
        chk("bp.rdy_back", 80'(ready_out), 80'(1'b1));
        @(negedge rc_clk);
        valid_in = 1'b0;
        chk("bp.c_dat", 80'(data_out), 80'(fc));
        chk("bp.c_dir", 80'(direction_out), 80'(4'b0001));
        chk("bp.c_vld", 80'(valid_out), 80'(1'b1));
        @(negedge rc_clk);
        chk("bp.empty", 80'(valid_out), 80'(1'b0));

        rc_ready = 1'b0;
        valid_in = 1'b1; data_in = mk(4'b0110, 2'b01, 22'h0D0D0);
        @(negedge rc_clk);
        data_in = mk(4'b0110, 2'b00, 22'h0E0E0);
        @(negedge rc_clk);
        valid_in = 1'b0;
        chk("mr.full", 80'(ready_out), 80'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("mr.vld", 80'(valid_out), 80'(1'b0));
        chk("mr.dir", 80'(direction_out), 80'(4'b1111));
        chk("mr.rdy", 80'(ready_out), 80'(1'b1));
        @(negedge rc_clk);
        rst_n = 1'b1;
        @(negedge rc_clk);
        chk("mr.still_empty", 80'(valid_out), 80'(1'b0));
        xfer("mr.body", mk(4'b0110, 2'b00, 22'h0F0F0), 4'b1111);

`ifdef RC_PKT_CNT_EN
        valid_in = 1'b0;
        rst_n = 1'b0;
        @(negedge rc_clk);
        rst_n = 1'b1;
        xfer("cnt.w1", mk(4'b0000, 2'b11, 22'h1), 4'b1000);
        xfer("cnt.w2", mk(4'b0001, 2'b11, 22'h2), 4'b1000);
        xfer("cnt.w3", mk(4'b0000, 2'b11, 22'h3), 4'b1000);
        xfer("cnt.none", mk(4'b0011, 2'b11, 22'h4), 4'b1111);
        valid_in = 1'b0;
        @(negedge rc_clk);
        chk("cnt.vec", pkt_cnt, {16'd3, 64'd0});
`endif

        valid_in = 1'b0;
        @(negedge rc_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
